// File: rtl/accum32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum32_pkg
//  Description : Shared types and constants for the streaming 32-bit
//                accumulator (state encoding, saturation limits, data width).
//  Revision    : 1.0 - initial release
// ============================================================================
package accum32_pkg;

    localparam int          DATA_W  = 32;
    localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [31:0] SAT_NEG = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : accum32_pkg
`default_nettype wire

// File: rtl/accum32_unit.sv
`default_nettype none
// ============================================================================
//  Module      : accum32_unit
//  Description : Streaming 32-bit signed accumulator. Drives an external
//                carry-select adder with (running total, current sample),
//                registers its sum on every accepted beat and presents the
//                burst total, beat count and sticky overflow flag on a
//                valid/ready result port.
//  Options     : ACCUM32_SATURATE_EN - clamp the running total to the signed
//                32-bit limits on overflow instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum32_unit
    import accum32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic [DATA_W-1:0]   add_a,
    output logic [DATA_W-1:0]   add_b,
    input  logic [DATA_W-1:0]   add_sum,
    input  logic                add_ovf,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_sum,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_ovf
);

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]    r_out_count;
    logic                r_out_ovf;

    logic                w_accept;
    logic                w_handshake;
    logic                w_enter_hold;
    logic [DATA_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_ovf_next;

    // The adder is outside this block: operand A is the running total,
    // operand B is the raw sample regardless of in_valid.
    assign add_a        = r_acc;
    assign add_b        = in_data;

    assign in_ready     = (r_state != HOLD);
    assign w_accept     = in_valid && in_ready;
    assign w_handshake  = r_out_valid && out_ready;
    assign w_enter_hold = w_accept && in_last;

`ifdef ACCUM32_SATURATE_EN
    // Overflow can only happen when both operands share a sign, so the sign
    // of the sample tells which rail the true sum ran past.
    assign w_acc_next   = add_ovf ? (in_data[DATA_W-1] ? SAT_NEG : SAT_POS) : add_sum;
`else
    assign w_acc_next   = add_sum;
`endif

    // Beat count sticks at all-ones rather than wrapping back to zero.
    assign w_count_next = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    assign w_ovf_next   = r_ovf | add_ovf;

    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_count    = r_out_count;
    assign out_ovf      = r_out_ovf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a last beat closes the burst, the result handshake reopens input.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_enter_hold) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_handshake) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Running total, beat count and sticky overflow; cleared once the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
        end else if (w_handshake) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end
    end

    // Result port: capture post-beat values on the last beat, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_enter_hold) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_next;
            r_out_count <= w_count_next;
            r_out_ovf   <= w_ovf_next;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule : accum32_unit
`default_nettype wire

// File: tb/tb_accum32_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum32_unit
//  Description : Self-checking bench for accum32_unit. Supplies the external
//                adder, runs directed bursts with literal expectations and a
//                randomized phase checked every cycle against a burst-level
//                arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum32_unit;

    localparam int CNT_W = 16;
`ifdef ACCUM32_SATURATE_EN
    localparam bit          SAT_MODE = 1'b1;
    localparam logic [31:0] EXP_OVF_SUM = 32'h7FFFFFFF;
`else
    localparam bit          SAT_MODE = 1'b0;
    localparam logic [31:0] EXP_OVF_SUM = 32'h80000000;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic [31:0]       add_sum;
    logic              add_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int tests = 0;
    int fails = 0;
    bit rnd   = 1'b0;

    // Reference model state: total, beats and overflow of the current burst.
    logic [31:0] m_acc;
    int          m_cnt;
    bit          m_ovf;
    bit          m_hold;

    always #5 clk = ~clk;

    // External carry-select adder stand-in (carry-in 0).
    assign add_sum = add_a + add_b;
    assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

    accum32_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_ovf   (add_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Add one sample to the model total using wide signed arithmetic.
    function automatic void model_add(input logic [31:0] x);
        longint t;
        t = longint'($signed(m_acc)) + longint'($signed(x));
        if (t > 64'sd2147483647 || t < -64'sd2147483648) begin
            m_ovf = 1'b1;
            if (SAT_MODE) m_acc = (t > 0) ? 32'h7FFFFFFF : 32'h80000000;
            else          m_acc = t[31:0];
        end else begin
            m_acc = t[31:0];
        end
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    endfunction

    // Per-cycle compare, sampled mid-cycle, then model advance for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            m_acc  = '0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_hold = 1'b0;
        end else begin
            check("in_ready",  in_ready,  !m_hold);
            check("out_valid", out_valid, m_hold);
            check("add_a",     add_a,     m_acc);
            check("add_b",     add_b,     in_data);
            if (m_hold) begin
                check("out_sum",   out_sum,   m_acc);
                check("out_count", out_count, m_cnt[CNT_W-1:0]);
                check("out_ovf",   out_ovf,   m_ovf);
            end
            if (!m_hold && in_valid) begin
                model_add(in_data);
                if (in_last) m_hold = 1'b1;
            end else if (m_hold && out_ready) begin
                m_acc  = '0;
                m_cnt  = 0;
                m_ovf  = 1'b0;
                m_hold = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom % 3) != 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = $urandom;
            step();
        end
    endtask

    // Present one sample and keep it until the unit accepts it (bounded).
    task automatic beat(input logic [31:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            step();
            @(negedge clk);
            n++;
        end
        check("accept_wait", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic check_result(input string tag, input logic [31:0] s, input int c, input logic o);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"},   out_sum,   s);
        check({tag, "_count"}, out_count, c[CNT_W-1:0]);
        check({tag, "_ovf"},   out_ovf,   o);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum",   out_sum,   32'd0);
        check("rst_out_count", out_count, 16'd0);
        check("rst_out_ovf",   out_ovf,   1'b0);
        check("rst_add_a",     add_a,     32'd0);

        // 3 + 5 - 2, result taken immediately
        beat(32'd3, 1'b0);
        beat(32'd5, 1'b0);
        beat(-32'sd2, 1'b1);
        check_result("b1", 32'd6, 3, 1'b0);
        step();
        check("b1_after_valid", out_valid, 1'b0);
        check("b1_after_ready", in_ready,  1'b1);

        // Single beat, consumer stalls while upstream keeps offering data
        out_ready = 1'b0;
        beat(32'h10, 1'b1);
        check_result("b2", 32'd16, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd99;
            step();
            check("b2_stall_sum",   out_sum,   32'd16);
            check("b2_stall_count", out_count, 16'd1);
            check("b2_stall_ready", in_ready,  1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("b2_taken", out_valid, 1'b0);

        // Signed overflow
        beat(32'h7FFFFFFF, 1'b0);
        beat(32'd1, 1'b1);
        check_result("b3", EXP_OVF_SUM, 2, 1'b1);
        step();

        // Negative total, then an immediate follow-up burst starts from zero
        beat(-32'sd5, 1'b0);
        beat(32'd2, 1'b1);
        check_result("b4", 32'hFFFFFFFD, 2, 1'b0);
        step();
        beat(32'd7, 1'b1);
        check_result("b5", 32'd7, 1, 1'b0);
        step();

        // Reset in the middle of a burst
        beat(32'd1, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd2;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_sum",   out_sum,   32'd0);
        check("mid_rst_count", out_count, 16'd0);
        check("mid_rst_ovf",   out_ovf,   1'b0);
        check("mid_rst_add_a", add_a,     32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        beat(32'd9, 1'b1);
        check_result("b6", 32'd9, 1, 1'b0);
        step();

        // Gapped input: only valid cycles count
        beat(32'd1, 1'b0);
        idle(1);
        beat(32'd2, 1'b0);
        idle(1);
        beat(32'd3, 1'b1);
        check_result("b7", 32'd6, 3, 1'b0);
        step();

        // Randomized bursts with random backpressure
        rnd = 1'b1;
        for (int b = 0; b < 60; b++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic [31:0] d;
                case ($urandom % 4)
                    0:       d = 32'h7FFFFF00 + ($urandom % 512);
                    1:       d = 32'h80000100 - ($urandom % 512);
                    2:       d = $urandom;
                    default: d = $urandom_range(0, 200) - 100;
                endcase
                beat(d, (i == len - 1));
                if ($urandom % 3 == 0) idle($urandom_range(1, 2));
            end
        end
        rnd       = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule : tb_accum32_unit
`default_nettype wire
